// File: rtl/vga_timing_generator.sv
// Pixel-enable-gated VGA raster timing: position, syncs, blanking and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the frame_count output.
module vga_timing_generator #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_PULSE  = 96,
  parameter int   H_BP     = 48,
  parameter logic H_POL    = 1'b0,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_PULSE  = 2,
  parameter int   V_BP     = 33,
  parameter logic V_POL    = 1'b0,
  parameter int   CW       = 10,
  parameter int   FRAME_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  // One extra bit so a window edge equal to the total never aliases to zero.
  localparam logic [CW:0] H_VIS     = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_LO = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_HI = (CW+1)'(H_ACTIVE + H_FP + H_PULSE);
  localparam logic [CW:0] V_VIS     = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_LO = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_HI = (CW+1)'(V_ACTIVE + V_FP + V_PULSE);

  if ((64'(H_TOTAL) - 64'd1) > ((64'd1 << CW) - 64'd1)) begin : g_bad_h_total
    $error("vga_timing_generator: H_TOTAL-1 does not fit in CW bits");
  end
  if ((64'(V_TOTAL) - 64'd1) > ((64'd1 << CW) - 64'd1)) begin : g_bad_v_total
    $error("vga_timing_generator: V_TOTAL-1 does not fit in CW bits");
  end
  if ((H_PULSE == 0) || (V_PULSE == 0)) begin : g_bad_pulse
    $error("vga_timing_generator: sync pulse width must be non-zero");
  end
  if (FRAME_W < 1) begin : g_bad_frame_w
    $error("vga_timing_generator: FRAME_W must be at least 1");
  end

  function automatic logic in_window(input logic [CW-1:0] pos,
                                     input logic [CW:0]   lo,
                                     input logic [CW:0]   hi);
    in_window = ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

  logic [CW-1:0] h_next_s;
  logic [CW-1:0] v_next_s;
  logic          h_wrap_s;
  logic          f_wrap_s;

  // Next raster position; decodes are taken from it so they line up with the counters.
  always_comb begin
    h_wrap_s = (hcount == H_LAST);
    f_wrap_s = h_wrap_s && (vcount == V_LAST);
    if (h_wrap_s) begin
      h_next_s = '0;
      if (vcount == V_LAST) begin
        v_next_s = '0;
      end else begin
        v_next_s = vcount + CNT_ONE;
      end
    end else begin
      h_next_s = hcount + CNT_ONE;
      v_next_s = vcount;
    end
  end

  // Counters, sync/blank decodes and strobes; reset parks on the last pixel of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hcount      <= h_next_s;
      vcount      <= v_next_s;
      hsync       <= in_window(h_next_s, H_SYNC_LO, H_SYNC_HI) ? H_POL : ~H_POL;
      vsync       <= in_window(v_next_s, V_SYNC_LO, V_SYNC_HI) ? V_POL : ~V_POL;
      video_on    <= ({1'b0, h_next_s} < H_VIS) && ({1'b0, v_next_s} < V_VIS);
      line_start  <= h_wrap_s;
      frame_start <= f_wrap_s;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter starts at all ones so the first frame after reset reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count <= '1;
    end else if (pix_en && f_wrap_s) begin
      frame_count <= frame_count + FRAME_W'(1'b1);
    end else begin
      frame_count <= frame_count;
    end
  end
`endif

endmodule
